// File: rtl/sync_req_responder.sv
// Receive-side responder: synchronises a level request, emits one
// valid/ready event per request and closes the 4-phase req/ack loop.
module sync_req_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16,
  parameter int TIMEOUT     = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_in,
  input  logic             evt_ready,
  input  logic             err_clr,
  output logic             evt_valid,
  output logic             ack_out,
  output logic             busy,
  output logic             timeout_err,
  output logic [CNT_W-1:0] evt_count
);

  localparam int TW = $clog2(TIMEOUT + 2);
  localparam logic [TW-1:0] TMO_HIT = TW'(TIMEOUT);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    VALID,
    ACK_HI,
    ACK_LO
  } state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [TW-1:0]          tmo_q, tmo_d;
  logic                   err_q, err_d;
  logic                   valid_q, valid_d;
  logic                   ack_q, ack_d;
  logic                   busy_q, busy_d;
  logic                   req_s;
  logic                   set_err;

  assign req_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], req_in};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmo_d   = '0;
    set_err = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_s) state_d = VALID;
      end
      VALID: begin
        if (evt_ready) begin
          cnt_d   = cnt_q + 1'b1;
          state_d = ACK_HI;
        end
      end
      ACK_HI: begin
        if (!req_s) begin
          state_d = ACK_LO;
        end else begin
          // Counter parks one past TIMEOUT so the error sets only once
          tmo_d = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + 1'b1;
          if (TIMEOUT != 0 && tmo_q == TMO_HIT) set_err = 1'b1;
        end
      end
      ACK_LO: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    err_d = err_q;
    if (set_err) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end
    valid_d = (state_d == VALID);
    ack_d   = (state_d == ACK_HI);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sync_q  <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

  assign evt_valid   = valid_q;
  assign ack_out     = ack_q;
  assign busy        = busy_q;
  assign timeout_err = err_q;
  assign evt_count   = cnt_q;

endmodule
